axis_packet_fifo_replay: RTL and testbench

//  Single-clock AXIS store-and-forward packet FIFO with commit/rewind at both ends.

---
 rtl/fifo_ptr_pkg.sv | 29 ++
 rtl/simple_dual_port_two_clocks.sv | 32 +++
 rtl/axis_packet_fifo_replay.sv | 118 +++++++++++
 tb/tb_axis_packet_fifo_replay.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the packet FIFOs. Each pointer carries one extra
// wrap bit above the RAM address so that full and empty can be told apart.
package fifo_ptr_pkg;

  // Width of one stored beat: {tlast, tdata, tuser}.
  function automatic int axis_data_width(input int axis_bytes, input int axis_user_bits);
    return 8 * axis_bytes + axis_user_bits + 1;
  endfunction

  // Full: the address bits match and the wrap bits differ. Only the low w bits
  // of each argument are meaningful.
  function automatic logic ptr_full(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] diff;
    logic [31:0] msb;
    diff = a ^ b;
    msb  = 32'd1 << (w - 1);
    return ((diff & (msb - 32'd1)) == 32'd0) && ((diff & msb) != 32'd0);
  endfunction

  // Empty: all w bits are equal, including the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] diff;
    logic [31:0] msb;
    diff = a ^ b;
    msb  = 32'd1 << (w - 1);
    return (diff & ((msb << 1) - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/simple_dual_port_two_clocks.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register holds its value while i_enb is low.
module simple_dual_port_two_clocks #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  i_clka,
  input  logic                  i_wea,
  input  logic [ADDR_WIDTH-1:0] i_addra,
  input  logic [DATA_WIDTH-1:0] i_dia,
  input  logic                  i_clkb,
  input  logic                  i_enb,
  input  logic [ADDR_WIDTH-1:0] i_addrb,
  output logic [DATA_WIDTH-1:0] o_dob
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_dob;

  // Write port.
  always_ff @(posedge i_clka) begin
    if (i_wea) r_mem[i_addra] <= i_dia;
  end

  // Registered read port.
  always_ff @(posedge i_clkb) begin
    if (i_enb) r_dob <= r_mem[i_addrb];
  end

  assign o_dob = r_dob;

endmodule

// File: rtl/axis_packet_fifo_replay.sv
// Store-and-forward AXIS packet FIFO with commit/rewind on both sides.
// The writer may abandon a partial packet (axis_i_drop); the reader may rewind
// to the start of the packet it is reading (axis_o_drop) and get it again.
// RAM space is released only when the reader accepts tlast without drop.
module axis_packet_fifo_replay
  import fifo_ptr_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int LOG2_DEPTH     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_sresetn,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_tlast,
  input  logic                      axis_i_drop,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_tlast,
  input  logic                      axis_o_drop
);

  localparam int DATA_WIDTH = axis_data_width(AXIS_BYTES, AXIS_USER_BITS);
  localparam int PW         = LOG2_DEPTH + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] r_wrptr;
  logic [PW-1:0] r_committed_wrptr;
  logic [PW-1:0] r_rdptr;
  logic [PW-1:0] r_committed_rdptr;
  logic          r_o_tvalid;

  logic                  w_full;
  logic                  w_available;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_replay;
  logic                  w_read_from_ram;
  logic [DATA_WIDTH-1:0] w_dia;
  logic [DATA_WIDTH-1:0] w_dob;

  // Full is judged against the committed read pointer: a packet being read
  // still owns its space until it is accepted without a rewind.
  assign w_full        = ptr_full(32'(r_wrptr), 32'(r_committed_rdptr), PW);
  assign axis_i_tready = !w_full;
  assign w_wr_hs       = axis_i_tvalid && !w_full;

  // Only committed packets are readable.
  assign w_available     = !ptr_empty(32'(r_rdptr), 32'(r_committed_wrptr), PW);
  assign w_rd_hs         = r_o_tvalid && axis_o_tready;
  assign w_replay        = w_rd_hs && axis_o_drop;
  assign w_read_from_ram = w_available && (!r_o_tvalid || axis_o_tready) && !w_replay;

  assign w_dia = {axis_i_tlast, axis_i_tdata, axis_i_tuser};

  simple_dual_port_two_clocks #(
    .ADDR_WIDTH (LOG2_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clka  (i_clk),
    .i_wea   (w_wr_hs),
    .i_addra (r_wrptr[LOG2_DEPTH-1:0]),
    .i_dia   (w_dia),
    .i_clkb  (i_clk),
    .i_enb   (w_read_from_ram),
    .i_addrb (r_rdptr[LOG2_DEPTH-1:0]),
    .o_dob   (w_dob)
  );

  // The RAM read register is the output data register; r_o_tvalid qualifies it.
  assign axis_o_tvalid = r_o_tvalid;
  assign axis_o_tlast  = w_dob[DATA_WIDTH-1];
  assign axis_o_tdata  = w_dob[DATA_WIDTH-2 -: 8*AXIS_BYTES];
  assign axis_o_tuser  = w_dob[AXIS_USER_BITS-1:0];

  // Write side: advance on each beat, commit on tlast, rewind on drop.
  always_ff @(posedge i_clk) begin
    if (!i_sresetn) begin
      r_wrptr           <= '0;
      r_committed_wrptr <= '0;
    end else if (w_wr_hs) begin
      if (axis_i_drop) begin
        r_wrptr <= r_committed_wrptr;
      end else begin
        r_wrptr <= r_wrptr + PTR_ONE;
        if (axis_i_tlast) r_committed_wrptr <= r_wrptr + PTR_ONE;
      end
    end
  end

  // Read side: prefetch into the output register, rewind on replay, and free
  // space once tlast is accepted. While a beat is presented r_rdptr already
  // points past it, so r_rdptr is exactly the post-tlast commit point.
  always_ff @(posedge i_clk) begin
    if (!i_sresetn) begin
      r_rdptr           <= '0;
      r_committed_rdptr <= '0;
      r_o_tvalid        <= 1'b0;
    end else begin
      if (w_replay) begin
        r_rdptr    <= r_committed_rdptr;
        r_o_tvalid <= 1'b0;
      end else if (w_read_from_ram) begin
        r_rdptr    <= r_rdptr + PTR_ONE;
        r_o_tvalid <= 1'b1;
      end else if (w_rd_hs) begin
        r_o_tvalid <= 1'b0;
      end
      if (w_rd_hs && axis_o_tlast && !axis_o_drop) r_committed_rdptr <= r_rdptr;
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo_replay.sv
// Bench for axis_packet_fifo_replay with LOG2_DEPTH=4: directed scenarios plus
// a randomised run, all backed by a packet scoreboard on the output side.
module tb_axis_packet_fifo_replay;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       srstn;
  logic       i_tvalid, i_tready, i_tlast, i_drop;
  logic [7:0] i_tdata;
  logic [0:0] i_tuser;
  logic       o_tvalid, o_tready, o_tlast, o_drop;
  logic [7:0] o_tdata;
  logic [0:0] o_tuser;

  always #5 clk = ~clk;

  axis_packet_fifo_replay #(
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (1),
    .LOG2_DEPTH     (4)
  ) dut (
    .i_clk         (clk),
    .i_sresetn     (srstn),
    .axis_i_tvalid (i_tvalid),
    .axis_i_tready (i_tready),
    .axis_i_tdata  (i_tdata),
    .axis_i_tuser  (i_tuser),
    .axis_i_tlast  (i_tlast),
    .axis_i_drop   (i_drop),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tready (o_tready),
    .axis_o_tdata  (o_tdata),
    .axis_o_tuser  (o_tuser),
    .axis_o_tlast  (o_tlast),
    .axis_o_drop   (o_drop)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  int errors = 0;
  int checks = 0;
  int committed_beats = 0;
  int committed_pkts = 0;
  int delivered_pkts = 0;

  beat_t exp_q[$];   // committed beats not yet delivered, in order
  beat_t cur_pkt[$]; // input packet being assembled
  int    ridx = 0;   // position of the next output beat inside exp_q

  // Scoreboard: sample both handshakes mid-cycle. Committed packets are pushed
  // on input tlast; output beats are compared, rewound on drop, popped on tlast.
  always @(negedge clk) begin
    beat_t got;
    if (srstn !== 1'b1) begin
      exp_q.delete();
      cur_pkt.delete();
      ridx = 0;
    end else begin
      if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
        got = '{d: o_tdata, u: o_tuser[0], l: o_tlast};
        checks++;
        if (ridx >= exp_q.size()) begin
          errors++;
          $display("FAIL sb_unexpected_beat got d=%02h u=%b l=%b required no beat", got.d, got.u, got.l);
        end else begin
          if (got !== exp_q[ridx]) begin
            errors++;
            $display("FAIL sb_beat got d=%02h u=%b l=%b required d=%02h u=%b l=%b",
                     got.d, got.u, got.l, exp_q[ridx].d, exp_q[ridx].u, exp_q[ridx].l);
          end
          if (o_drop) begin
            ridx = 0;
          end else if (exp_q[ridx].l) begin
            for (int k = 0; k <= ridx; k++) void'(exp_q.pop_front());
            ridx = 0;
            delivered_pkts++;
          end else begin
            ridx++;
          end
        end
      end
      if (i_tvalid === 1'b1 && i_tready === 1'b1) begin
        if (i_drop) begin
          cur_pkt.delete();
        end else begin
          cur_pkt.push_back('{d: i_tdata, u: i_tuser[0], l: i_tlast});
          if (i_tlast) begin
            checks++;
            if (cur_pkt.size() > DEPTH) begin
              errors++;
              $display("FAIL pkt_len_contract got len=%0d required <=%0d", cur_pkt.size(), DEPTH);
            end
            foreach (cur_pkt[k]) exp_q.push_back(cur_pkt[k]);
            committed_beats += cur_pkt.size();
            committed_pkts++;
            cur_pkt.delete();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_drop   = 1'b0;
  endtask

  task automatic drive_in(input logic [7:0] d, input logic u, input logic l, input logic dr);
    i_tvalid   = 1'b1;
    i_tdata    = d;
    i_tuser[0] = u;
    i_tlast    = l;
    i_drop     = dr;
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    idle_in();
    i_tdata = 8'h00;
    i_tuser = 1'b0;
    o_tready = 1'b0;
    o_drop = 1'b0;
    repeat (2) tick();
    srstn = 1'b1;
    checks++;
    if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b required 0", o_tvalid); end
    checks++;
    if (i_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b required 1", i_tready); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    o_tready = 1'b1;
    o_drop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      d = 8'(i + 1);
      drive_in(d, i[0], i == 2, 1'b0);
      checks++;
      if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_hold cyc=%0d got tvalid=%b required 0", i, o_tvalid); end
    end
    tick();
    idle_in();
    checks++;
    if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_latency got tvalid=%b required 0", o_tvalid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      d = 8'(i + 1);
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== d || o_tlast !== (i == 2)) begin
        errors++;
        $display("FAIL basic_beat%0d got v=%b d=%02h l=%b required v=1 d=%02h l=%b", i, o_tvalid, o_tdata, o_tlast, d, i == 2);
      end
    end
    tick();
    checks++;
    if (o_tvalid !== 1'b0) begin errors++; $display("FAIL basic_end got tvalid=%b required 0", o_tvalid); end
  endtask

  task automatic test_input_drop();
    int n = 0;
    o_tready = 1'b1;
    o_drop = 1'b0;
    tick(); drive_in(8'hA0, 1'b0, 1'b0, 1'b0);
    tick(); drive_in(8'hA1, 1'b1, 1'b0, 1'b0);
    tick(); drive_in(8'hA2, 1'b0, 1'b0, 1'b1);
    tick(); drive_in(8'hB0, 1'b1, 1'b1, 1'b0);
    tick(); idle_in();
    for (int k = 0; k < 6; k++) begin
      if (o_tvalid === 1'b1) begin
        n++;
        checks++;
        if (o_tdata !== 8'hB0 || o_tlast !== 1'b1) begin
          errors++;
          $display("FAIL drop_beat got d=%02h l=%b required d=b0 l=1", o_tdata, o_tlast);
        end
      end
      tick();
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL drop_count got %0d beats required 1", n); end
  endtask

  task automatic test_replay();
    logic [7:0] d;
    o_tready = 1'b0;
    o_drop = 1'b0;
    tick(); drive_in(8'h10, 1'b0, 1'b0, 1'b0);
    tick(); drive_in(8'h11, 1'b1, 1'b0, 1'b0);
    tick(); drive_in(8'h12, 1'b0, 1'b1, 1'b0);
    tick(); idle_in();
    tick();
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== 8'h10) begin errors++; $display("FAIL replay_first got v=%b d=%02h required v=1 d=10", o_tvalid, o_tdata); end
    o_tready = 1'b1;
    tick();
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== 8'h11) begin errors++; $display("FAIL replay_second got v=%b d=%02h required v=1 d=11", o_tvalid, o_tdata); end
    o_drop = 1'b1;
    tick();
    o_drop = 1'b0;
    checks++;
    if (o_tvalid !== 1'b0) begin errors++; $display("FAIL replay_gap got tvalid=%b required 0", o_tvalid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      d = 8'(8'h10 + i);
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== d || o_tlast !== (i == 2)) begin
        errors++;
        $display("FAIL replay_beat%0d got v=%b d=%02h l=%b required v=1 d=%02h l=%b", i, o_tvalid, o_tdata, o_tlast, d, i == 2);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
        errors++;
        $display("FAIL replay_empty got v=%b rdy=%b required v=0 rdy=1", o_tvalid, i_tready);
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] d;
    o_tready = 1'b0;
    o_drop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (i_tready !== 1'b1) begin errors++; $display("FAIL full_room beat=%0d got tready=%b required 1", i, i_tready); end
      drive_in(8'(i), i[1], i == DEPTH - 1, 1'b0);
    end
    tick();
    idle_in();
    checks++;
    if (i_tready !== 1'b0) begin errors++; $display("FAIL full_flag got tready=%b required 0", i_tready); end
    tick();
    o_tready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        d = 8'(k);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== d || o_tlast !== (k == DEPTH - 1)) begin
          errors++;
          $display("FAIL full_pass%0d_beat%0d got v=%b d=%02h l=%b required v=1 d=%02h l=%b", p, k, o_tvalid, o_tdata, o_tlast, d, k == DEPTH - 1);
        end
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL full_held pass%0d beat%0d got tready=%b required 0", p, k, i_tready); end
        o_drop = (p == 0 && k == DEPTH - 1);
        tick();
      end
      o_drop = 1'b0;
      if (p == 0) begin
        checks++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b0) begin
          errors++;
          $display("FAIL full_replay_gap got v=%b rdy=%b required v=0 rdy=0", o_tvalid, i_tready);
        end
        tick();
      end
    end
    checks++;
    if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL full_freed got rdy=%b v=%b required rdy=1 v=0", i_tready, o_tvalid);
    end
  endtask

  task automatic test_random();
    int pkt = 0, len, beat = 0, drop_at, cyc = 0;
    int start_beats = committed_beats;
    int start_pkts = committed_pkts;
    int start_deliv = delivered_pkts;
    logic in_acc;
    logic done = 1'b0;
    len = $urandom_range(1, DEPTH);
    drop_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
    while (cyc < 60000 && !done) begin
      if (pkt < 200) begin
        i_tvalid   = ($urandom_range(0, 3) != 0);
        i_tdata    = 8'($urandom);
        i_tuser[0] = 1'($urandom);
        i_tlast    = (beat == len - 1);
        i_drop     = (beat == drop_at);
      end else begin
        idle_in();
      end
      o_tready = ($urandom_range(0, 3) != 0);
      o_drop   = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      in_acc = i_tvalid && i_tready;
      tick();
      cyc++;
      if (in_acc) begin
        if (i_drop || beat == len - 1) begin
          pkt++;
          beat = 0;
          len = $urandom_range(1, DEPTH);
          drop_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        end else begin
          beat++;
        end
      end
      if (pkt >= 200 && exp_q.size() == 0) done = 1'b1;
    end
    idle_in();
    o_drop = 1'b0;
    o_tready = 1'b1;
    checks++;
    if (!done) begin errors++; $display("FAIL random_timeout got %0d undelivered beats required 0", exp_q.size()); end
    checks++;
    if (delivered_pkts - start_deliv != committed_pkts - start_pkts) begin
      errors++;
      $display("FAIL random_exactly_once got delivered=%0d required %0d", delivered_pkts - start_deliv, committed_pkts - start_pkts);
    end
    checks++;
    if (committed_beats - start_beats <= 20 * 2 * DEPTH) begin
      errors++;
      $display("FAIL random_wraps got %0d beats required >%0d", committed_beats - start_beats, 20 * 2 * DEPTH);
    end
    repeat (3) tick();
    checks++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
      errors++;
      $display("FAIL random_drained got v=%b rdy=%b required v=0 rdy=1", o_tvalid, i_tready);
    end
  endtask

  task automatic test_reset_mid();
    o_tready = 1'b1;
    o_drop = 1'b0;
    tick(); drive_in(8'h20, 1'b0, 1'b0, 1'b0);
    tick(); drive_in(8'h21, 1'b1, 1'b0, 1'b0);
    tick(); drive_in(8'h22, 1'b0, 1'b1, 1'b0);
    tick(); idle_in();
    tick();
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== 8'h20) begin errors++; $display("FAIL rstmid_first got v=%b d=%02h required v=1 d=20", o_tvalid, o_tdata); end
    tick();
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    checks++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state got v=%b rdy=%b required v=0 rdy=1", o_tvalid, i_tready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_empty cyc=%0d got tvalid=%b required 0", k, o_tvalid); end
    end
    tick(); drive_in(8'hC0, 1'b1, 1'b1, 1'b0);
    tick(); idle_in();
    tick();
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== 8'hC0 || o_tuser !== 1'b1 || o_tlast !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_c0 got v=%b d=%02h u=%b l=%b required v=1 d=c0 u=1 l=1", o_tvalid, o_tdata, o_tuser, o_tlast);
    end
    tick();
    checks++;
    if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_after got tvalid=%b required 0", o_tvalid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_drop();
    test_replay();
    test_full();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #3ms;
    $display("FAIL watchdog got no finish required finish before 3ms");
    $fatal(1, "watchdog expired");
  end

endmodule
